striping_ctrl: RTL

Lane scheduler in front of the two-lane striping datapath. Accepts a 32-bit word stream with a valid/ready handshake and generates a link-training sequence after enable. In x2 mode it distributes accepted words round-robin onto lane 0 and lane 1; in x1 mode all words go to lane 0. Downstream lane buffers apply backpressure, and the block never drops or duplicates a word.

---
 rtl/striping_ctrl_pkg.sv | 15 +
 rtl/striping_train_cnt.sv | 32 +++
 rtl/striping_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/striping_ctrl_pkg.sv
// Shared encodings for the two-lane striping scheduler.
package striping_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRAIN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam logic MODE_X1 = 1'b0;
  localparam logic MODE_X2 = 1'b1;

  localparam logic [31:0] IDLE_SYM_DEFAULT = 32'h0000_00BC;

endpackage

// File: rtl/striping_train_cnt.sv
// Training-word counter: counts emissions, saturates at TRAIN_WORDS.
module striping_train_cnt #(
  parameter int unsigned TRAIN_WORDS = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_last,
  output logic o_done
);

  localparam int unsigned CNT_W = $clog2(TRAIN_WORDS + 1);

  logic [CNT_W-1:0] r_cnt;

  // Count enabled emissions; clear has priority, count holds once saturated.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_W'(TRAIN_WORDS))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // o_last marks the count before the final emission.
  assign o_last = (r_cnt == CNT_W'(TRAIN_WORDS - 1));
  assign o_done = (r_cnt == CNT_W'(TRAIN_WORDS));

endmodule

// File: rtl/striping_ctrl.sv
// Lane scheduler: link training, then round-robin (x2) or single-lane (x1) striping.
module striping_ctrl
  import striping_ctrl_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       TRAIN_WORDS = 16,
  parameter logic [DATA_W-1:0] IDLE_SYM    = DATA_W'(IDLE_SYM_DEFAULT)
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              link_en,
  input  logic              lane_mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [1:0]        lane_full,
  output logic [DATA_W-1:0] lane_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              train_done
);

  state_e            r_state;
  logic              r_mode;
  logic              r_ptr;
  logic [DATA_W-1:0] r_lane0;
  logic [DATA_W-1:0] r_lane1;
  logic              r_valid0;
  logic              r_valid1;
  logic              r_train_done;

  state_e            w_state_d;
  logic              w_mode_d;
  logic              w_ptr_d;
  logic [DATA_W-1:0] w_lane0_d;
  logic [DATA_W-1:0] w_lane1_d;
  logic              w_valid0_d;
  logic              w_valid1_d;
  logic              w_cnt_clr;
  logic              w_cnt_last;
  logic              w_cnt_done;
  logic              w_any_full;
  logic              w_ready;
  logic              w_xfer;
  logic              w_emit;

  // In x1 only lane 0 backpressure matters.
  assign w_any_full = (r_mode == MODE_X2) ? (|lane_full) : lane_full[0];
  assign w_ready    = (r_state == ST_ACTIVE) && !lane_full[r_ptr];
  assign w_xfer     = valid_in && w_ready;
  // Dropping link_en abandons training immediately, so no emission that cycle.
  assign w_emit     = (r_state == ST_TRAIN) && link_en && !w_any_full && !w_cnt_done;

  striping_train_cnt #(
    .TRAIN_WORDS(TRAIN_WORDS)
  ) u_train_cnt (
    .i_clk  (clk_2f),
    .i_rst  (reset),
    .i_en   (w_emit),
    .i_clr  (w_cnt_clr),
    .o_last (w_cnt_last),
    .o_done (w_cnt_done)
  );

  // Next-state, pointer and lane register inputs.
  always_comb begin
    w_state_d  = r_state;
    w_mode_d   = r_mode;
    w_ptr_d    = r_ptr;
    w_lane0_d  = r_lane0;
    w_lane1_d  = r_lane1;
    w_valid0_d = 1'b0;
    w_valid1_d = 1'b0;
    w_cnt_clr  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_ptr_d   = 1'b0;
        w_cnt_clr = 1'b1;
        if (link_en) begin
          w_state_d = ST_TRAIN;
          w_mode_d  = lane_mode;
        end
      end
      ST_TRAIN: begin
        if (!link_en) begin
          w_state_d = ST_IDLE;
          w_ptr_d   = 1'b0;
          w_cnt_clr = 1'b1;
        end else if (w_emit) begin
          w_lane0_d  = IDLE_SYM;
          w_valid0_d = 1'b1;
          if (r_mode == MODE_X2) begin
            w_lane1_d  = IDLE_SYM;
            w_valid1_d = 1'b1;
          end
          if (w_cnt_last) begin
            w_state_d = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: begin
        // A transfer accepted in the same cycle link_en falls still completes.
        if (w_xfer) begin
          if (r_ptr == 1'b0) begin
            w_lane0_d  = data_in;
            w_valid0_d = 1'b1;
          end else begin
            w_lane1_d  = data_in;
            w_valid1_d = 1'b1;
          end
          if (r_mode == MODE_X2) begin
            w_ptr_d = ~r_ptr;
          end
        end
        if (!link_en) begin
          w_state_d = ST_IDLE;
          w_ptr_d   = 1'b0;
          w_cnt_clr = 1'b1;
        end
      end
      default: begin
        w_state_d = ST_IDLE;
        w_ptr_d   = 1'b0;
        w_cnt_clr = 1'b1;
      end
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mode       <= MODE_X1;
      r_ptr        <= 1'b0;
      r_lane0      <= '0;
      r_lane1      <= '0;
      r_valid0     <= 1'b0;
      r_valid1     <= 1'b0;
      r_train_done <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_mode       <= w_mode_d;
      r_ptr        <= w_ptr_d;
      r_lane0      <= w_lane0_d;
      r_lane1      <= w_lane1_d;
      r_valid0     <= w_valid0_d;
      r_valid1     <= w_valid1_d;
      r_train_done <= (w_state_d == ST_ACTIVE);
    end
  end

  assign ready_out  = w_ready;
  assign lane_0     = r_lane0;
  assign lane_1     = r_lane1;
  assign valid_out0 = r_valid0;
  assign valid_out1 = r_valid1;
  assign train_done = r_train_done;

endmodule
